// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop sync, debounce, press/release/click/long event pulses.
// Optional auto-repeat of btn_press after a long press, enabled by BTN_AUTOREPEAT_EN.

module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES     = 64,
  parameter int unsigned REPEAT_CYCLES   = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_click,
  output logic btn_long
);

  typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StRelDb} state_e;

  localparam logic [CNT_W-1:0] DbMax   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LongVal = CNT_W'(LONG_CYCLES);
  // A hold target beyond the saturation value of the hold counter never fires btn_long.
  localparam bit LongReachable = (64'(LONG_CYCLES) < (64'd1 << CNT_W));

  state_e           state_q, state_d;
  logic             btn_meta, btn_s;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d, hold_inc;
  logic             long_fired_q, long_fired_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             click_q, click_d;
  logic             long_q, long_d;
  logic             entering_held, releasing, in_hold;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (btn_s) state_d = StPressDb;
      StPressDb: begin
        if (!btn_s) begin
          state_d = StIdle;
        end else if (db_cnt_q == DbMax) begin
          state_d = StHeld;
        end
      end
      StHeld:    if (!btn_s) state_d = StRelDb;
      StRelDb: begin
        if (btn_s) begin
          state_d = StHeld;
        end else if (db_cnt_q == DbMax) begin
          state_d = StIdle;
        end
      end
      default:   state_d = StIdle;
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RepVal = CNT_W'(REPEAT_CYCLES);

  logic [CNT_W-1:0] rep_q, rep_d, rep_inc;
  logic             staying_held, rep_fire;

  // Repeats only run while continuously held after btn_long; any exit restarts the period.
  always_comb begin
    staying_held = (state_q == StHeld) && (state_d == StHeld);
    rep_inc      = rep_q + CNT_W'(1);
    rep_fire     = staying_held && long_fired_q && (rep_inc == RepVal);
    rep_d        = (staying_held && long_fired_q && !rep_fire) ? rep_inc : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  logic unused_repeat_cycles;
  assign unused_repeat_cycles = ^REPEAT_CYCLES;
`endif

  // Output and counter next-state logic; every output is registered below
  always_comb begin
    entering_held = (state_q == StPressDb) && (state_d == StHeld);
    releasing     = (state_q == StRelDb) && (state_d == StIdle);
    in_hold       = (state_q == StHeld) || (state_q == StRelDb);
    hold_inc      = (hold_q == '1) ? hold_q : hold_q + CNT_W'(1);

    unique case (state_q)
      StIdle:    db_cnt_d = btn_s ? CNT_W'(1) : '0;
      StPressDb: db_cnt_d = (!btn_s || db_cnt_q == DbMax) ? '0 : db_cnt_q + CNT_W'(1);
      StHeld:    db_cnt_d = btn_s ? '0 : CNT_W'(1);
      StRelDb:   db_cnt_d = (btn_s || db_cnt_q == DbMax) ? '0 : db_cnt_q + CNT_W'(1);
      default:   db_cnt_d = '0;
    endcase

    long_d = LongReachable && in_hold && !releasing && !long_fired_q && (hold_inc == LongVal);

    if (entering_held) begin
      hold_d       = '0;
      long_fired_d = 1'b0;
    end else if (in_hold) begin
      hold_d       = hold_inc;
      long_fired_d = long_fired_q | long_d;
    end else begin
      hold_d       = '0;
      long_fired_d = 1'b0;
    end

    level_d   = (state_d == StHeld) || (state_d == StRelDb);
    release_d = releasing;
    click_d   = releasing && !long_fired_q;
`ifdef BTN_AUTOREPEAT_EN
    press_d   = entering_held | rep_fire;
`else
    press_d   = entering_held;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta     <= 1'b0;
      btn_s        <= 1'b0;
      db_cnt_q     <= '0;
      hold_q       <= '0;
      long_fired_q <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      click_q      <= 1'b0;
      long_q       <= 1'b0;
    end else begin
      btn_meta     <= btn_raw;
      btn_s        <= btn_meta;
      db_cnt_q     <= db_cnt_d;
      hold_q       <= hold_d;
      long_fired_q <= long_fired_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      click_q      <= click_d;
      long_q       <= long_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_click   = click_q;
  assign btn_long    = long_q;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Conditions one raw, asynchronous, active-high push-button input for the watch chip. It produces clean single-cycle event pulses and a stable level. It sits directly upstream of backlight_controller, whose btn_backlight input is driven by btn_press, and of the other mode/set button consumers. It provides synchronisation, debounce, short-click and long-press classification, and optional auto-repeat.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive clk cycles the synchronised input must hold a new value before it is accepted (legal range 1 to 2^CNT_W-1).
LONG_CYCLES, 64, clk cycles after btn_press, with the button still held, at which btn_long fires (must be greater than DEBOUNCE_CYCLES).
REPEAT_CYCLES, 16, auto-repeat period in clk cycles (used only with BTN_AUTOREPEAT_EN).
CNT_W, 16, width of the internal debounce counter and the hold counter.

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
btn_raw  input  1  raw button pin, asynchronous, may bounce
btn_level  output  1  debounced button level
btn_press  output  1  one-cycle pulse on accepted press
btn_release  output  1  one-cycle pulse on accepted release
btn_click  output  1  one-cycle pulse on accepted release when btn_long did not fire during this hold
btn_long  output  1  one-cycle pulse, at most once per hold, when the hold reaches LONG_CYCLES

Behaviour:
- Reset: synchronous, active-high, sampled on posedge clk. It clears the sync flops, both counters and the FSM (state to IDLE), and drives all outputs to 0. Reset dominates every other event, including a reset that arrives mid-debounce or mid-hold.
- Synchroniser: btn_raw passes through 2 flops to give btn_s. All logic uses btn_s only.
- FSM states:
  - IDLE (level 0). btn_s=1 goes to PRESS_DB and loads the debounce counter with 1.
  - PRESS_DB. btn_s=1 increments the counter. When the counter equals DEBOUNCE_CYCLES, go to HELD. btn_s=0 at any point returns to IDLE and clears the counter, with no pulse.
  - HELD (level 1). On entry: btn_press=1 for 1 cycle, the hold counter and the long_fired flag are cleared, and btn_level rises in the same cycle. The hold counter increments each cycle and saturates at all-ones. When hold == LONG_CYCLES and long_fired=0: btn_long=1 for 1 cycle and long_fired is set. btn_s=0 goes to REL_DB and loads the debounce counter with 1.
  - REL_DB (level stays 1). btn_s=0 increments the counter. When the counter equals DEBOUNCE_CYCLES, go to IDLE. btn_s=1 returns to HELD; this does not re-pulse btn_press and does not clear the hold counter or long_fired. The hold counter keeps counting in REL_DB.
  - On entry to IDLE from REL_DB: btn_release=1 and btn_level=0 in the same cycle. btn_click=1 in that cycle if long_fired=0.
- Latency: after btn_raw rises cleanly (no bounce), btn_press is high in exactly the cycle that is 2+DEBOUNCE_CYCLES posedges after the first edge that samples btn_raw=1. Release latency is identical.
- Pulse exclusivity:
  - btn_press, btn_long and btn_release never assert in the same cycle.
  - btn_click asserts only together with btn_release.
- btn_long fires at most once per hold. With LONG_CYCLES beyond the saturation value it never fires.
- All outputs are registered, so there are no combinational paths from btn_raw.

Optional Feature:
Macro BTN_AUTOREPEAT_EN.
- Defined: after btn_long fires, while the FSM is in HELD, btn_press re-pulses every REPEAT_CYCLES cycles. The first repeat comes REPEAT_CYCLES cycles after the btn_long pulse. The repeat counter clears on leaving HELD, and no repeats are emitted during REL_DB.
- Not defined: btn_press pulses exactly once per hold, and no repeat counter logic is present.

Test Plan:
- Reset hold: reset=1 for 3 cycles with btn_raw=1 -> all outputs 0, state IDLE. Release reset with btn_raw still 1 -> btn_press at cycle 2+16=18 after the first sampling edge.
- Bounce: btn_raw high 10 cycles, low 3, then high 40 -> no pulse from the first burst. One btn_press at 18 cycles after the final rise. btn_level stays 1 until release.
- Short click: clean press of 30 cycles, then release -> btn_press once, then btn_release and btn_click together 18 cycles after the fall. btn_long never fires.
- Long press: hold 200 cycles -> btn_long exactly once, 64 cycles after btn_press. On release, btn_release=1 and btn_click=0.
- Release glitch: while HELD, btn_raw low for 5 cycles, then high -> no btn_release, no second btn_press, hold count continues. btn_long timing is unchanged.
- BTN_AUTOREPEAT_EN defined, hold 150 cycles past btn_long -> btn_press pulses at +16, +32, … after btn_long (9 pulses). Same stimulus without the macro -> 0 repeats.
